// File: rtl/load_store_unit.sv
//------------------------------------------------------------------------------
// load_store_unit: single-outstanding RV32 load/store unit with byte lanes
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module load_store_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_wdata,
  input  logic [31:0] in_inst,
  output logic        out_valid,
  output logic [31:0] out_data,
  output logic        out_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam logic [6:0] c_op_load  = 7'b0000011;
  localparam logic [6:0] c_op_store = 7'b0100011;

  localparam logic [1:0] c_idle   = 2'd0;
  localparam logic [1:0] c_access = 2'd1;
  localparam logic [1:0] c_done   = 2'd2;

  logic [1:0]  r_state;
  logic [1:0]  w_next;

  logic [29:0] r_word;
  logic [1:0]  r_offset;
  logic [2:0]  r_func3;
  logic        r_we;
  logic [31:0] r_wdata;
  logic [3:0]  r_wmask;
  logic [31:0] r_data;
  logic        r_err;

  logic [6:0]  w_opcode;
  logic [2:0]  w_func3;
  logic        w_is_load;
  logic        w_is_store;
  logic        w_misaligned;
  logic        w_legal;
  logic        w_accept;
  logic [3:0]  w_wmask;
  logic [31:0] w_wdata;
  logic [31:0] w_shifted;
  logic [31:0] w_load_data;
  logic        w_unused_inst;

  assign w_opcode      = in_inst[6:0];
  assign w_func3       = in_inst[14:12];
  assign w_unused_inst = ^{in_inst[31:15], in_inst[11:7]};
  assign w_accept      = in_valid && (r_state == c_idle);

  always_comb begin
    w_is_load  = (w_opcode == c_op_load) &&
                 ((w_func3 == 3'b000) || (w_func3 == 3'b001) || (w_func3 == 3'b010) ||
                  (w_func3 == 3'b100) || (w_func3 == 3'b101));
    w_is_store = (w_opcode == c_op_store) && !w_func3[2] && (w_func3[1:0] != 2'b11);
    w_misaligned = ((w_func3[1:0] == 2'b01) && in_addr[0]) ||
                   ((w_func3[1:0] == 2'b10) && (in_addr[1:0] != 2'b00));
    w_legal = (w_is_load || w_is_store) && !w_misaligned;
  end

  // Replicate store data across all lanes so the mask alone selects bytes.
  always_comb begin
    w_wmask = 4'b1111;
    w_wdata = in_wdata;
    case (w_func3[1:0])
      2'b00: begin
        w_wmask = 4'b0001 << in_addr[1:0];
        w_wdata = {4{in_wdata[7:0]}};
      end
      2'b01: begin
        w_wmask = in_addr[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{in_wdata[15:0]}};
      end
      default: begin
        w_wmask = 4'b1111;
        w_wdata = in_wdata;
      end
    endcase
  end

  assign w_shifted = mem_rdata >> {r_offset, 3'b000};

  always_comb begin
    w_load_data = w_shifted;
    case (r_func3)
      3'b000:  w_load_data = {{24{w_shifted[7]}},  w_shifted[7:0]};
      3'b001:  w_load_data = {{16{w_shifted[15]}}, w_shifted[15:0]};
      3'b100:  w_load_data = {24'd0, w_shifted[7:0]};
      3'b101:  w_load_data = {16'd0, w_shifted[15:0]};
      default: w_load_data = w_shifted;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= c_idle;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      c_idle:   if (in_valid) w_next = w_legal ? c_access : c_done;
      c_access: if (mem_ack) w_next = c_done;
      c_done:   w_next = c_idle;
      default:  w_next = c_idle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_word   <= 30'd0;
      r_offset <= 2'd0;
      r_func3  <= 3'd0;
      r_we     <= 1'b0;
      r_wdata  <= 32'd0;
      r_wmask  <= 4'd0;
      r_data   <= 32'd0;
      r_err    <= 1'b0;
    end else if (w_accept) begin
      r_word   <= in_addr[31:2];
      r_offset <= in_addr[1:0];
      r_func3  <= w_func3;
      r_we     <= w_is_store;
      r_wdata  <= w_wdata;
      r_wmask  <= w_is_store ? w_wmask : 4'b0000;
      r_data   <= 32'd0;
      r_err    <= !w_legal;
    end else if ((r_state == c_access) && mem_ack) begin
      r_data   <= r_we ? 32'd0 : w_load_data;
      r_err    <= 1'b0;
    end
  end

  // Bus fields are forced to zero outside ACCESS so idle/reset state is clean.
  always_comb begin
    in_ready  = (r_state == c_idle);
    mem_req   = (r_state == c_access);
    mem_we    = (r_state == c_access) && r_we;
    mem_addr  = (r_state == c_access) ? {r_word, 2'b00} : 32'd0;
    mem_wdata = (r_state == c_access) ? r_wdata : 32'd0;
    mem_wmask = (r_state == c_access) ? r_wmask : 4'b0000;
    out_valid = (r_state == c_done);
    out_data  = (r_state == c_done) ? r_data : 32'd0;
    out_err   = (r_state == c_done) && r_err;
  end

endmodule

`default_nettype wire

// File: tb/tb_load_store_unit.sv
//------------------------------------------------------------------------------
// tb_load_store_unit: directed bench with a reference model of the LSU rules
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_addr = 32'd0;
  logic [31:0] in_wdata = 32'd0;
  logic [31:0] in_inst = 32'd0;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = 32'd0;

  int tests = 0;
  int fails = 0;
  bit started = 1'b0;

  bit ack_auto = 1'b1;
  bit ack_force = 1'b0;
  int ack_wait = 0;
  int req_cnt = 0;

  load_store_unit dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_addr(in_addr), .in_wdata(in_wdata), .in_inst(in_inst),
    .out_valid(out_valid), .out_data(out_data), .out_err(out_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mk_inst(input logic [6:0] op, input logic [2:0] f3);
    return {17'd0, f3, 5'd0, op};
  endfunction

  // Memory responder: acknowledges after ack_wait request cycles.
  always begin
    @(posedge clk);
    #2;
    if (mem_req) begin
      mem_ack = (ack_auto && (req_cnt == ack_wait)) || ack_force;
      req_cnt++;
    end else begin
      mem_ack = ack_force;
      req_cnt = 0;
    end
  end

  // Reference model: phase 0 = can accept, 1 = memory outstanding, 2 = reporting.
  int          m_phase = 0;
  logic [31:0] m_addr, m_wdata, m_res;
  logic [3:0]  m_wmask;
  logic        m_we, m_err;
  int          m_f3, m_off;
  int          t_f3, t_bytes;
  bit          t_ld, t_st;

  function automatic logic [31:0] extract(input int f3, input int off, input logic [31:0] w);
    logic [31:0] b, h;
    b = (w >> (8 * off)) & 32'hFF;
    h = (w >> (8 * off)) & 32'hFFFF;
    case (f3)
      0: return (b >= 128) ? b - 32'd256 : b;
      1: return (h >= 32768) ? h - 32'd65536 : h;
      4: return b;
      5: return h;
      default: return w;
    endcase
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_phase = 0;
    end else begin
      case (m_phase)
        0: if (in_valid) begin
          t_f3 = int'(in_inst[14:12]);
          t_ld = (in_inst[6:0] == 7'h03) &&
                 (t_f3 == 0 || t_f3 == 1 || t_f3 == 2 || t_f3 == 4 || t_f3 == 5);
          t_st = (in_inst[6:0] == 7'h23) && (t_f3 <= 2);
          t_bytes = 1 << (t_f3 % 4);
          if ((t_ld || t_st) && (in_addr % t_bytes == 0)) begin
            m_phase = 1;
            m_addr  = in_addr & ~32'd3;
            m_off   = int'(in_addr % 4);
            m_f3    = t_f3;
            m_we    = t_st;
            if (!t_st)       begin m_wmask = 4'd0;  m_wdata = 32'd0; end
            else if (t_f3 == 0) begin
              m_wmask = 4'(1 << m_off);  m_wdata = in_wdata[7:0] * 32'h01010101;
            end else if (t_f3 == 1) begin
              m_wmask = 4'(3 << (m_off & 2)); m_wdata = in_wdata[15:0] * 32'h00010001;
            end else begin
              m_wmask = 4'hF;  m_wdata = in_wdata;
            end
          end else begin
            m_phase = 2; m_res = 32'd0; m_err = 1'b1;
          end
        end
        1: if (mem_ack) begin
          m_phase = 2;
          m_res = m_we ? 32'd0 : extract(m_f3, m_off, mem_rdata);
          m_err = 1'b0;
        end
        default: m_phase = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (started) begin
      check("in_ready", {31'd0, in_ready}, {31'd0, m_phase == 0});
      check("mem_req", {31'd0, mem_req}, {31'd0, m_phase == 1});
      check("out_valid", {31'd0, out_valid}, {31'd0, m_phase == 2});
      if (m_phase == 1) begin
        check("mem_addr", mem_addr, m_addr);
        check("mem_we", {31'd0, mem_we}, {31'd0, m_we});
        check("mem_wmask", {28'd0, mem_wmask}, {28'd0, m_wmask});
        if (m_we) check("mem_wdata", mem_wdata, m_wdata);
      end
      if (m_phase == 2) begin
        check("out_data", out_data, m_res);
        check("out_err", {31'd0, out_err}, {31'd0, m_err});
      end
    end
  end

  task automatic issue(input logic [31:0] inst, input logic [31:0] addr, input logic [31:0] wd);
    in_inst = inst; in_addr = addr; in_wdata = wd; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!out_valid && n < 20) begin tick(); n++; end
    check("out_valid_timeout", {31'd0, out_valid}, 32'd1);
  endtask

  typedef struct {
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rd;
  } op_t;

  op_t ops[8];
  int  nreq;

  initial begin
    ops[0] = '{7'h03, 3'b001, 32'h0000_0012, 32'h0,         32'h8001_ABCD};
    ops[1] = '{7'h03, 3'b100, 32'h0000_0003, 32'h0,         32'h80FF_1234};
    ops[2] = '{7'h03, 3'b000, 32'h0000_0001, 32'h0,         32'h0000_7F00};
    ops[3] = '{7'h03, 3'b101, 32'h0000_0000, 32'h0,         32'h1234_FFFE};
    ops[4] = '{7'h23, 3'b001, 32'h0000_0006, 32'hAAAA_5566, 32'h0};
    ops[5] = '{7'h23, 3'b010, 32'h0000_0008, 32'hDEAD_BEEF, 32'h0};
    ops[6] = '{7'h03, 3'b001, 32'h0000_0003, 32'h0,         32'h0};
    ops[7] = '{7'h23, 3'b011, 32'h0000_0000, 32'h0,         32'h0};

    tick(); tick();
    reset = 1'b0;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_mem_req", {31'd0, mem_req}, 32'd0);
    check("rst_mem_we", {31'd0, mem_we}, 32'd0);
    check("rst_out_err", {31'd0, out_err}, 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_mem_wmask", {28'd0, mem_wmask}, 32'd0);
    started = 1'b1;

    // Stray ack while idle must be ignored.
    ack_force = 1'b1; tick(); ack_force = 1'b0; tick();

    // LB 0x103, ack on first request cycle.
    ack_wait = 0; mem_rdata = 32'h80FF_1234;
    issue(mk_inst(7'h03, 3'b000), 32'h0000_0103, 32'h0);
    check("lb_mem_addr", mem_addr, 32'h0000_0100);
    check("lb_mem_wmask", {28'd0, mem_wmask}, 32'd0);
    tick();
    check("lb_valid_2cyc", {31'd0, out_valid}, 32'd1);
    check("lb_data", out_data, 32'hFFFF_FF80);
    tick();

    // LHU 0x202, three wait cycles.
    ack_wait = 3; mem_rdata = 32'hBEEF_0000;
    issue(mk_inst(7'h03, 3'b101), 32'h0000_0202, 32'h0);
    nreq = 0;
    while (mem_req && nreq < 20) begin
      check("lhu_addr_stable", mem_addr, 32'h0000_0200);
      nreq++;
      tick();
    end
    check("lhu_req_cycles", nreq, 32'd4);
    check("lhu_valid", {31'd0, out_valid}, 32'd1);
    check("lhu_data", out_data, 32'h0000_BEEF);
    check("lhu_err", {31'd0, out_err}, 32'd0);
    tick();

    // SB 0x001.
    ack_wait = 1;
    issue(mk_inst(7'h23, 3'b000), 32'h0000_0001, 32'h1234_56AB);
    check("sb_we", {31'd0, mem_we}, 32'd1);
    check("sb_addr", mem_addr, 32'h0);
    check("sb_wmask", {28'd0, mem_wmask}, 32'h2);
    check("sb_wdata", mem_wdata, 32'hABAB_ABAB);
    wait_valid();
    check("sb_out_data", out_data, 32'd0);
    tick();

    // Misaligned LW and non-memory opcode.
    issue(mk_inst(7'h03, 3'b010), 32'h0000_0006, 32'h0);
    check("lw_mis_valid", {31'd0, out_valid}, 32'd1);
    check("lw_mis_err", {31'd0, out_err}, 32'd1);
    check("lw_mis_data", out_data, 32'd0);
    check("lw_mis_req", {31'd0, mem_req}, 32'd0);
    tick();
    issue(mk_inst(7'h13, 3'b000), 32'h0000_0000, 32'h0);
    check("opimm_err", {31'd0, out_err}, 32'd1);
    check("opimm_req", {31'd0, mem_req}, 32'd0);
    tick();

    // Assorted patterns checked against the model.
    for (int i = 0; i < 8; i++) begin
      ack_wait = i % 3; mem_rdata = ops[i].rd;
      issue(mk_inst(ops[i].op, ops[i].f3), ops[i].addr, ops[i].wd);
      wait_valid();
      tick();
    end

    // SW aborted by reset, followed by a late ack.
    ack_auto = 1'b0;
    issue(mk_inst(7'h23, 3'b010), 32'h0000_0010, 32'h5555_AAAA);
    check("abort_req_up", {31'd0, mem_req}, 32'd1);
    tick();
    reset = 1'b1; tick(); reset = 1'b0;
    check("abort_req_down", {31'd0, mem_req}, 32'd0);
    check("abort_ready", {31'd0, in_ready}, 32'd1);
    ack_force = 1'b1; tick(); ack_force = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("abort_no_valid", {31'd0, out_valid}, 32'd0);
      tick();
    end
    ack_auto = 1'b1;

    // Reset wins over acceptance in the same cycle.
    reset = 1'b1;
    issue(mk_inst(7'h03, 3'b010), 32'h0000_0020, 32'h0);
    reset = 1'b0;
    check("rst_prio_req", {31'd0, mem_req}, 32'd0);
    check("rst_prio_ready", {31'd0, in_ready}, 32'd1);

    // Back-to-back LW with immediate acks; second op held on the inputs.
    ack_wait = 0; mem_rdata = 32'h1122_3344;
    issue(mk_inst(7'h03, 3'b010), 32'h0000_0040, 32'h0);
    check("b2b_ready_access", {31'd0, in_ready}, 32'd0);
    in_inst = mk_inst(7'h03, 3'b010); in_addr = 32'h0000_0044; in_valid = 1'b1;
    tick();
    check("b2b_ready_done", {31'd0, in_ready}, 32'd0);
    check("b2b_data1", out_data, 32'h1122_3344);
    mem_rdata = 32'hCAFE_F00D;
    tick();
    check("b2b_ready_idle", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    check("b2b_addr2", mem_addr, 32'h0000_0044);
    tick();
    check("b2b_valid2", {31'd0, out_valid}, 32'd1);
    check("b2b_data2", out_data, 32'hCAFE_F00D);
    tick(); tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
